// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through an IDLE -> EXEC -> RESP handshake.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'h0
`define ALU_OP_SUB  4'h1
`define ALU_OP_AND  4'h2
`define ALU_OP_OR   4'h3
`define ALU_OP_XOR  4'h4
`define ALU_OP_SLL  4'h5
`define ALU_OP_SRL  4'h6
`define ALU_OP_SRA  4'h7
`define ALU_OP_SLT  4'h8
`define ALU_OP_SLTU 4'h9
`endif

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] res,
  output logic        err
);
  always_comb begin
    res = '0;
    err = 1'b0;
    case (op)
      `ALU_OP_ADD:  res = a + b;
      `ALU_OP_SUB:  res = a - b;
      `ALU_OP_AND:  res = a & b;
      `ALU_OP_OR:   res = a | b;
      `ALU_OP_XOR:  res = a ^ b;
      `ALU_OP_SLL:  res = a << b[4:0];
      `ALU_OP_SRL:  res = a >> b[4:0];
      `ALU_OP_SRA:  res = $signed(a) >>> b[4:0];
      `ALU_OP_SLT:  res = {31'b0, $signed(a) < $signed(b)};
      `ALU_OP_SLTU: res = {31'b0, a < b};
      default:      err = 1'b1;  // undefined codes complete with a zero result
    endcase
  end
endmodule

module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic        i_req1_valid,
  output logic        o_req0_ready,
  output logic        o_req1_ready,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [3:0]  i_req0_op,
  input  logic [3:0]  i_req1_op,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_res,
  output logic        o_rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  vld;
  logic        gnt_id;
  logic        accept;
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic [31:0] alu_res;
  logic        alu_err;

  assign vld = {i_req1_valid, i_req0_valid};

`ifdef ALU_ARBITER_RR_EN
  logic last_q;

  // On a tie the requester that lost last time wins; reset favours requester 0.
  assign gnt_id = (vld == 2'b11) ? ~last_q : (vld[1] & ~vld[0]);

  always_ff @(posedge i_clk) begin
    if (i_rst)       last_q <= 1'b1;
    else if (accept) last_q <= gnt_id;
  end
`else
  assign gnt_id = vld[1] & ~vld[0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if ((|vld) && !i_rst) begin
        accept    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_req0_ready = accept & ~gnt_id;
  assign o_req1_ready = accept &  gnt_id;
  assign o_rsp_valid  = (state == RESP);

  // Operands are captured at accept so requesters may drop valid immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      o_rsp_id  <= 1'b0;
      o_rsp_res <= '0;
      o_rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= gnt_id ? i_req1_a  : i_req0_a;
        b_q      <= gnt_id ? i_req1_b  : i_req0_b;
        op_q     <= gnt_id ? i_req1_op : i_req0_op;
        o_rsp_id <= gnt_id;
      end
      if (state == EXEC) begin
        o_rsp_res <= alu_res;
        o_rsp_err <= alu_err;
      end
    end
  end

  alu u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (alu_res),
    .err (alu_err)
  );
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses are queued at drive time and
// checked whenever o_rsp_valid is high; handshake timing is checked every cycle.

module tb_alu_arbiter;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_BAD  = 4'hF;

`ifdef ALU_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0_valid, i_req1_valid;
  logic        o_req0_ready, o_req1_ready;
  logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [3:0]  i_req0_op, i_req1_op;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic        o_rsp_id;
  logic [31:0] o_rsp_res;
  logic        o_rsp_err;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req1_valid (i_req1_valid),
    .o_req0_ready (o_req0_ready),
    .o_req1_ready (o_req1_ready),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .i_req0_op    (i_req0_op),
    .i_req1_op    (i_req1_op),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_res    (o_rsp_res),
    .o_rsp_err    (o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] res, input logic err);
    rsp_t e;
    e.id  = id;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endtask

  // One clock: sample at negedge, then return 1 time unit after the next posedge.
  // While a response is held it is compared against the queue head every cycle.
  task automatic cycle(input logic ev, input logic er0, input logic er1);
    rsp_t e;
    @(negedge i_clk);
    chk1("rsp_valid", o_rsp_valid, ev);
    chk1("req0_ready", o_req0_ready, er0);
    chk1("req1_ready", o_req1_ready, er1);
    if (o_rsp_valid) begin
      chk1("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk1("rsp_id", o_rsp_id, e.id);
        chk32("rsp_res", o_rsp_res, e.res);
        chk1("rsp_err", o_rsp_err, e.err);
        if (i_rsp_ready) void'(sb.pop_front());
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic rst_outs();
    chk1("rst_valid", o_rsp_valid, 1'b0);
    chk32("rst_res", o_rsp_res, 32'h0);
    chk1("rst_id", o_rsp_id, 1'b0);
    chk1("rst_err", o_rsp_err, 1'b0);
  endtask

  initial begin
    logic id;
    i_rst = 1'b1;
    i_req0_valid = 1'b1;  // readies must stay low while reset is held
    i_req1_valid = 1'b0;
    i_req0_a = 32'd0; i_req0_b = 32'd0; i_req0_op = OP_ADD;
    i_req1_a = 32'd0; i_req1_b = 32'd0; i_req1_op = OP_ADD;
    i_rsp_ready = 1'b0;
    @(posedge i_clk); #1;
    cycle(1'b0, 1'b0, 1'b0);
    i_req0_valid = 1'b0;
    i_rst = 1'b0;
    rst_outs();

    // Single op with latency check: accept at 0, response at 2, idle at 3.
    i_req0_valid = 1'b1; i_req0_a = 32'd5; i_req0_b = 32'd7; i_req0_op = OP_ADD;
    i_rsp_ready = 1'b1;
    push(1'b0, 32'd12, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    i_req0_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Backpressure: consumer not ready for 4 cycles, response must hold.
    i_req1_valid = 1'b1; i_req1_a = 32'd3; i_req1_b = 32'd5; i_req1_op = OP_SUB;
    i_rsp_ready = 1'b0;
    push(1'b1, 32'hFFFF_FFFE, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    i_req1_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    i_rsp_ready = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Contention: both valid continuously.
    i_req0_valid = 1'b1; i_req0_a = 32'hF0; i_req0_b = 32'h0F; i_req0_op = OP_XOR;
    i_req1_valid = 1'b1; i_req1_a = 32'd1;  i_req1_b = 32'd2;  i_req1_op = OP_SLTU;
    for (int k = 0; k < 4; k++) begin
      id = RR ? k[0] : 1'b0;
      push(id, id ? 32'd1 : 32'hFF, 1'b0);
      cycle(1'b0, ~id, id);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
    end
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);

    // Reset during EXEC abandons the op; no response may appear.
    i_req1_valid = 1'b1; i_req1_a = 32'd1; i_req1_b = 32'd1; i_req1_op = OP_ADD;
    cycle(1'b0, 1'b0, 1'b1);
    i_req1_valid = 1'b0;
    i_rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    rst_outs();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // After reset requester 0 wins a tie; its undefined op completes with err.
    i_req0_valid = 1'b1; i_req0_a = 32'd1; i_req0_b = 32'd2; i_req0_op = OP_BAD;
    i_req1_valid = 1'b1; i_req1_a = 32'd9; i_req1_b = 32'd9; i_req1_op = OP_ADD;
    push(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    chk1("sb_drained", sb.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
